seg_scan_driver: RTL and testbench
==================================

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter DIGITS, default 4: number of multiplexed digits, legal range 1..8.
REQ-002 Parameter CLK_DIV, default 50000: clk cycles per digit slot, legal minimum 2.
REQ-003 Parameter ACTIVE_LOW, default 1: 1 = seg/dp/en active-low; 0 = all three inverted.
REQ-004 clk  input  1  single clock; all state is on the rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 data_in  input  4*DIGITS  hex nibbles; nibble k drives digit k (digit 0 = [3:0]).
REQ-007 dp_in  input  DIGITS  decimal point request per digit.
REQ-008 load  input  1  single-cycle strobe; captures data_in/dp_in.
REQ-009 blank  input  1  level; forces the display dark.
REQ-010 seg  output  7  segments a..g (bit 6 = a); registered.
REQ-011 dp  output  1  decimal point of the current digit; registered.
REQ-012 en  output  DIGITS  digit enables, one active at most; registered.
REQ-013 frame_done  output  1  one-cycle pulse at the end of the last digit slot.
REQ-014 pending  output  1  high while a loaded value waits for the frame boundary.

Function
REQ-015 Prescaler counts 0..CLK_DIV-1 and wraps; tick = (count == CLK_DIV-1).
REQ-016 Digit index advances 0..DIGITS-1 on tick and wraps to 0; boundary = tick with index DIGITS-1.
REQ-017 frame_done is registered high for exactly the cycle after each boundary.
REQ-018 load with no boundary in the same cycle: data goes to the shadow register and pending = 1; a repeat load overwrites the shadow.
REQ-019 At a boundary with pending = 1: shadow copies to the active register and pending clears in the same edge.
REQ-020 load coincident with a boundary: data_in/dp_in go straight to active, and pending ends 0.
REQ-021 Display tearing is forbidden; active changes only at boundaries.
REQ-022 Outputs reflect the index and active value with 1-cycle latency (registered from the current index).
REQ-023 Glyphs use the shared hex table: 0->0000001, 1->1001111, 4->1001100, 5->0100100, 8->0000000, A->0001000, F->0111000 (ACTIVE_LOW = 1).
REQ-024 blank = 1: next cycle en = all inactive, seg = off, dp = off; the prescaler, index, load and pending logic keep running.
REQ-025 Unused prescaler/index states (non-power-of-2 DIGITS) wrap to 0 and never enable a digit.

Reset
REQ-026 reset_n low immediately clears: prescaler 0, index 0, active 0, shadow 0, pending 0, frame_done 0.
REQ-027 During reset: en = all inactive, seg = 1111111, dp = 1 (ACTIVE_LOW = 1 encoding).
REQ-028 Reset mid-frame discards any pending load; after release, the first slot is digit 0 showing 0 only after the first frame boundary (dark until then).

Configuration
REQ-029 Macro SEG_SCAN_LZB_EN defined: leading-zero blanking; digit k is dark in its slot when all nibbles k..DIGITS-1 are 0 and dp_in for k..DIGITS-1 is 0; digit 0 is never blanked.
REQ-030 Macro SEG_SCAN_LZB_EN undefined: every digit is displayed in its slot; the blanking logic is absent.

Structure
REQ-031 Package seg_pkg holds the 16-entry hex-to-segment table (function hex_to_seg), SEG_OFF = 7'b1111111, and the digit-index width function.
REQ-032 Sub-module seg_scan_prescaler(clk, reset_n, tick) parametrised by CLK_DIV; everything else stays in seg_scan_driver.

Verification (DIGITS = 4, CLK_DIV = 4, ACTIVE_LOW = 1)
REQ-033 Release reset, load 16'h1234 -> after the first frame_done: slot 0 en = 1110 seg = 1001100; slot 3 en = 0111 seg = 1001111; frame_done every 16 cycles.
REQ-034 Load 16'hABCD mid-frame -> pending = 1 and 1234 shown until the boundary; next frame shows D,C,B,A; pending drops with the boundary.
REQ-035 Load 16'h5555 in the boundary cycle -> pending stays 0, and the next slot 0 shows seg = 0100100.
REQ-036 blank = 1 for 10 cycles -> en = 1111 and seg = 1111111 from the next cycle; frame_done cadence unchanged.
REQ-037 SEG_SCAN_LZB_EN, data 16'h0050 -> digits 3, 2 dark, digit 1 = 0100100, digit 0 = 0000001; add dp_in = 4'b1000 -> digits 3..0 all lit, digit 3 dp = 0.
REQ-038 reset_n low mid-slot 2 -> same cycle en = 1111, pending = 0; after release, index restarts at 0.

Source files
------------

// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
//   Shared definitions for the multiplexed seven-segment scan driver.
//   Contents:
//     SEG_OFF    - all segments dark in active-low encoding (bit 6 = a).
//     hex_to_seg - 16-entry hex nibble to segment table, active-low, a..g.
//     idx_width  - bit width of a digit index for a given digit count.
// -----------------------------------------------------------------------------
package seg_pkg;

  localparam logic [6:0] SEG_OFF = 7'b1111111;

  // Active-low glyphs, bit 6 = segment a ... bit 0 = segment g.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000; // 4'hF
    endcase
    return s;
  endfunction

  // A single-digit display still needs a one-bit index register.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg_scan_prescaler.sv
// -----------------------------------------------------------------------------
// seg_scan_prescaler
//   Free-running divider that marks the last clock of every digit slot.
//   Ports:
//     clk     - clock, rising edge.
//     reset_n - asynchronous active-low reset (counter to 0).
//     tick    - high while the counter sits at CLK_DIV-1 (combinational).
//   Parameters:
//     CLK_DIV - clock cycles per digit slot, minimum 2.
// -----------------------------------------------------------------------------
module seg_scan_prescaler #(
  parameter int CLK_DIV = 50000
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int              CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] r_count;

  assign tick = (r_count == LAST);

  // The >= compare folds any unreachable count value back to 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (r_count >= LAST) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seg_scan_driver
//   Time-multiplexed driver for a DIGITS-wide seven-segment display. A new
//   value is captured on 'load' into a shadow register and only promoted to
//   the displayed (active) register at a frame boundary, so one scan frame
//   never mixes old and new digits.
//
//   Ports:
//     clk        - clock, rising edge.
//     reset_n    - asynchronous active-low reset.
//     data_in    - 4*DIGITS hex nibbles, nibble k -> digit k.
//     dp_in      - decimal point request per digit.
//     load       - single-cycle capture strobe for data_in/dp_in.
//     blank      - level, forces the display dark (scan keeps running).
//     seg        - segments a..g, bit 6 = a, registered.
//     dp         - decimal point of the current digit, registered.
//     en         - digit enables, at most one active, registered.
//     frame_done - one-cycle pulse after the last slot of each frame.
//     pending    - a loaded value is waiting for the frame boundary.
//
//   Parameters: DIGITS (1..8), CLK_DIV (>=2), ACTIVE_LOW (1 = outputs
//   active-low, 0 = seg/dp/en all inverted).
//
//   Build option: define SEG_SCAN_LZB_EN for leading-zero blanking.
// -----------------------------------------------------------------------------
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int CLK_DIV    = 50000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic                  blank,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     en,
  output logic                  frame_done,
  output logic                  pending
);

  localparam int               IDX_W    = idx_width(DIGITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  // Internal encoding is active-low; INV flips everything for active-high.
  localparam logic              INV      = (ACTIVE_LOW == 0);
  localparam logic [6:0]        SEG_DARK = SEG_OFF ^ {7{INV}};
  localparam logic              DP_DARK  = 1'b1 ^ INV;
  localparam logic [DIGITS-1:0] EN_DARK  = {DIGITS{~INV}};

  logic                  w_tick;
  logic                  w_boundary;

  logic [IDX_W-1:0]      r_idx;
  logic                  r_frame_done;
  logic [4*DIGITS-1:0]   r_active_data;
  logic [DIGITS-1:0]     r_active_dp;
  logic [4*DIGITS-1:0]   r_shadow_data;
  logic [DIGITS-1:0]     r_shadow_dp;
  logic                  r_pending;
  logic                  r_live;

  logic [6:0]            r_seg;
  logic                  r_dp;
  logic [DIGITS-1:0]     r_en;

  logic [DIGITS-1:0]     w_onehot;
  logic [3:0]            w_nib;
  logic                  w_dp_sel;
  logic                  w_digit_on;
  logic                  w_lz_dark;
  logic                  w_show;
  logic [6:0]            w_seg_next;
  logic                  w_dp_next;
  logic [DIGITS-1:0]     w_en_next;

  // ---------------------------------------------------------------------------
  // Slot timing
  // ---------------------------------------------------------------------------
  seg_scan_prescaler #(
    .CLK_DIV (CLK_DIV)
  ) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (w_tick)
  );

  assign w_boundary = w_tick && (r_idx == IDX_LAST);

  // Index values above DIGITS-1 (non-power-of-2 DIGITS) return to 0 on tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idx <= '0;
    end else if (w_tick) begin
      if (r_idx >= IDX_LAST) begin
        r_idx <= '0;
      end else begin
        r_idx <= r_idx + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_boundary;
    end
  end

  // ---------------------------------------------------------------------------
  // Shadow / active capture. A load on the boundary bypasses the shadow so
  // the freshest value wins and nothing is left pending.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_active_data <= '0;
      r_active_dp   <= '0;
      r_shadow_data <= '0;
      r_shadow_dp   <= '0;
      r_pending     <= 1'b0;
    end else if (load && w_boundary) begin
      r_active_data <= data_in;
      r_active_dp   <= dp_in;
      r_pending     <= 1'b0;
    end else if (load) begin
      r_shadow_data <= data_in;
      r_shadow_dp   <= dp_in;
      r_pending     <= 1'b1;
    end else if (w_boundary && r_pending) begin
      r_active_data <= r_shadow_data;
      r_active_dp   <= r_shadow_dp;
      r_pending     <= 1'b0;
    end
  end

  // Display stays dark after reset until the first frame boundary, so the
  // first lit slot is always digit 0 at the start of a whole frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_live <= 1'b0;
    end else if (w_boundary) begin
      r_live <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Digit select
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_onehot
      assign w_onehot[gi] = (r_idx == IDX_W'(gi));
    end
  endgenerate

  // An out-of-range index matches no bit, so no digit gets enabled.
  assign w_digit_on = |w_onehot;

  always_comb begin
    w_nib    = 4'h0;
    w_dp_sel = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (w_onehot[k]) begin
        w_nib    = r_active_data[4*k +: 4];
        w_dp_sel = r_active_dp[k];
      end
    end
  end

`ifdef SEG_SCAN_LZB_EN
  // Digit k is a leading zero when it and every higher digit carry a zero
  // nibble and no decimal point. Digit 0 always shows.
  logic [DIGITS-1:0] w_lz_vec;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_lzb
      if (gi == 0) begin : g_first
        assign w_lz_vec[gi] = 1'b0;
      end else begin : g_upper
        assign w_lz_vec[gi] = (r_active_data[4*DIGITS-1:4*gi] == '0) &&
                              (r_active_dp[DIGITS-1:gi] == '0);
      end
    end
  endgenerate

  assign w_lz_dark = |(w_onehot & w_lz_vec);
`else
  assign w_lz_dark = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Output register: one cycle behind the index it was computed from.
  // ---------------------------------------------------------------------------
  assign w_show     = r_live && !blank && w_digit_on && !w_lz_dark;
  assign w_seg_next = w_show ? (hex_to_seg(w_nib) ^ {7{INV}}) : SEG_DARK;
  assign w_dp_next  = w_show ? ((~w_dp_sel) ^ INV) : DP_DARK;
  assign w_en_next  = w_show ? ((~w_onehot) ^ {DIGITS{INV}}) : EN_DARK;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_seg <= SEG_DARK;
      r_dp  <= DP_DARK;
      r_en  <= EN_DARK;
    end else begin
      r_seg <= w_seg_next;
      r_dp  <= w_dp_next;
      r_en  <= w_en_next;
    end
  end

  assign seg        = r_seg;
  assign dp         = r_dp;
  assign en         = r_en;
  assign frame_done = r_frame_done;
  assign pending    = r_pending;

endmodule

// File: tb/tb_seg_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_driver
//   Self-checking bench for seg_scan_driver (DIGITS=4, CLK_DIV=4,
//   ACTIVE_LOW=1). The reference model tracks time as an edge count since
//   reset release: slot, digit and frame position follow from division,
//   and loads are applied as whole-frame transactions.
//   Honours SEG_SCAN_LZB_EN when the design is built with it.
// -----------------------------------------------------------------------------
module tb_seg_scan_driver;

  localparam int D     = 4;
  localparam int CD    = 4;
  localparam int FRAME = D * CD;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic        load;
  logic        blank;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  en;
  logic        frame_done;
  logic        pending;

  always #5 clk = ~clk;

  seg_scan_driver #(
    .DIGITS     (D),
    .CLK_DIV    (CD),
    .ACTIVE_LOW (1)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .data_in    (data_in),
    .dp_in      (dp_in),
    .load       (load),
    .blank      (blank),
    .seg        (seg),
    .dp         (dp),
    .en         (en),
    .frame_done (frame_done),
    .pending    (pending)
  );

  // Active-low glyphs, bit 6 = a.
  logic [6:0] glyph [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  int total = 0;
  int bad   = 0;

  // Model state
  int          m_n;
  logic [15:0] m_act;
  logic [3:0]  m_act_dp;
  logic [15:0] m_sh;
  logic [3:0]  m_sh_dp;
  bit          m_pend;
  bit          m_live;
  logic [3:0]  e_en;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic        e_fd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (edge %0d)", tag, got, want, m_n);
    end
  endtask

  task automatic model_reset();
    m_n      = 0;
    m_act    = '0;
    m_act_dp = '0;
    m_sh     = '0;
    m_sh_dp  = '0;
    m_pend   = 1'b0;
    m_live   = 1'b0;
  endtask

  function automatic bit lz_dark(input int idx);
`ifdef SEG_SCAN_LZB_EN
    return (idx != 0) && ((m_act >> (4*idx)) == 16'h0) && ((m_act_dp >> idx) == 4'h0);
`else
    return (idx < 0);
`endif
  endfunction

  // Drive one cycle of inputs, predict the outcome of the coming edge,
  // then compare at the following falling edge.
  task automatic cycle(input bit ld, input logic [15:0] d, input logic [3:0] p, input bit bl);
    int idx;
    bit bnd;
    load    = ld;
    data_in = d;
    dp_in   = p;
    blank   = bl;
    idx = (m_n / CD) % D;
    bnd = ((m_n % FRAME) == FRAME - 1);
    if (bl || !m_live || lz_dark(idx)) begin
      e_en  = 4'hF;
      e_seg = 7'h7F;
      e_dp  = 1'b1;
    end else begin
      e_en  = 4'hF ^ (4'd1 << idx);
      e_seg = glyph[m_act[4*idx +: 4]];
      e_dp  = ~m_act_dp[idx];
    end
    e_fd = bnd;
    if (ld && bnd) begin
      m_act    = d;
      m_act_dp = p;
      m_pend   = 1'b0;
    end else if (ld) begin
      m_sh    = d;
      m_sh_dp = p;
      m_pend  = 1'b1;
    end else if (bnd && m_pend) begin
      m_act    = m_sh;
      m_act_dp = m_sh_dp;
      m_pend   = 1'b0;
    end
    if (bnd) m_live = 1'b1;
    m_n++;
    @(posedge clk);
    @(negedge clk);
    chk("en",         32'(en),         32'(e_en));
    chk("seg",        32'(seg),        32'(e_seg));
    chk("dp",         32'(dp),         32'(e_dp));
    chk("frame_done", 32'(frame_done), 32'(e_fd));
    chk("pending",    32'(pending),    32'(m_pend));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 16'($urandom), 4'($urandom), 1'b0);
  endtask

  task automatic idle_until(input int phase);
    for (int i = 0; i < FRAME && (m_n % FRAME) != phase; i++) idle(1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_en"},      32'(en),         32'hF);
    chk({tag, "_seg"},     32'(seg),        32'h7F);
    chk({tag, "_dp"},      32'(dp),         32'h1);
    chk({tag, "_fd"},      32'(frame_done), 32'h0);
    chk({tag, "_pending"}, 32'(pending),    32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=running want=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    load    = 1'b0;
    blank   = 1'b0;
    data_in = '0;
    dp_in   = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;

    $display("txn: load 1234 right after reset release");
    cycle(1'b1, 16'h1234, 4'h0, 1'b0);
    idle(2 * FRAME + 2);

    $display("txn: load ABCD mid-frame");
    idle_until(6);
    cycle(1'b1, 16'hABCD, 4'h0, 1'b0);
    idle(2 * FRAME);

    $display("txn: load 5555 in boundary cycle");
    idle_until(FRAME - 1);
    cycle(1'b1, 16'h5555, 4'h0, 1'b0);
    idle(FRAME + 4);

    $display("txn: blank for 10 cycles");
    for (int i = 0; i < 10; i++) cycle(1'b0, 16'($urandom), 4'($urandom), 1'b1);
    idle(FRAME);

    $display("txn: 800 random cycles");
    for (int i = 0; i < 800; i++) begin
      cycle(($urandom_range(0, 7) == 0), 16'($urandom), 4'($urandom),
            ($urandom_range(0, 9) == 0));
    end

    $display("txn: reset mid-slot 2 with a pending load");
    idle_until(2 * CD);
    cycle(1'b1, 16'($urandom), 4'($urandom), 1'b0);
    load    = 1'b0;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("held_reset");
    reset_n = 1'b1;
    idle(FRAME + 3);
    cycle(1'b1, 16'h0F80, 4'h2, 1'b0);
    idle(2 * FRAME);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
